imem_fetch_sequencer: RTL and testbench
=======================================

IMEM_FETCH_SEQUENCER -- requirements
Module: imem_fetch_sequencer

Interface
REQ-001 SHALL have parameter W, default 8, the byte width of the shared instruction memory port.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  core requests an instruction fetch.
REQ-005 SHALL have port req_addr  input  4*W  byte address of the instruction; only bits [5:0] are used.
REQ-006 SHALL have port req_ready  output  1  fetch request accepted this cycle.
REQ-007 SHALL have port rsp_valid  output  1  assembled instruction available.
REQ-008 SHALL have port rsp_data  output  4*W  assembled instruction.
REQ-009 SHALL have port rsp_ready  input  1  core consumes the response.
REQ-010 SHALL have port wr_valid  input  1  loader requests a byte write.
REQ-011 SHALL have port wr_addr  input  6  loader byte address.
REQ-012 SHALL have port wr_data  input  W  loader byte data.
REQ-013 SHALL have port wr_ready  output  1  loader write performed this cycle.
REQ-014 SHALL have port mem_addr  output  6  byte address to the 64-entry memory.
REQ-015 SHALL have port mem_we  output  1  memory write enable.
REQ-016 SHALL have port mem_wdata  output  W  memory write data.
REQ-017 SHALL have port mem_rdata  input  W  combinational read data for mem_addr.

Function
REQ-018 SHALL implement FSM states IDLE, READ, RESP; reset state IDLE.
REQ-019 SHALL, in IDLE, arbitrate fetch vs. write with a 1-bit last-grant flag: on tie, grant the requester not granted last; single requester always wins.
REQ-020 SHALL drive wr_ready, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data combinationally in the IDLE cycle a write is granted; the write completes in that cycle, and the FSM stays in IDLE.
REQ-021 SHALL assert req_ready combinationally in IDLE when the fetch is granted, latch req_addr[5:0] as base, clear the byte counter, and enter READ.
REQ-022 SHALL, in READ, drive mem_addr = base + cnt (6-bit, wraps 63->0), mem_we=0, and capture mem_rdata into rsp_data[cnt*W +: W] (little-endian: byte at base to bits [W-1:0]).
REQ-023 SHALL enter RESP after the cnt=3 capture; no alignment is required.
REQ-024 SHALL assert rsp_valid only in RESP, holding rsp_data stable until rsp_ready=1, then return to IDLE.
REQ-025 SHALL, for a fetch accepted in cycle T with rsp_ready held high, assert rsp_valid in cycle T+5 and accept the next request no earlier than T+6.
REQ-026 SHALL hold wr_ready=0 and req_ready=0 in READ and RESP; pending requests wait.
REQ-027 SHALL ignore req_addr[4*W-1:6] and hold mem_we=0 except under REQ-020.

Reset
REQ-028 SHALL, on reset, enter IDLE; clear rsp_valid, rsp_data, cnt and base to 0; set the last-grant flag to fetch, so a write wins the first tie.
REQ-029 SHALL abort any READ/RESP in progress when reset is asserted, with no response and no memory write issued.

Verification (memory preloaded mem[i]=i, W=8)
REQ-030 SHALL pass: fetch req_addr=0x04 accepted at T -> rsp_valid at T+5, rsp_data=0x07060504.
REQ-031 SHALL pass: fetch req_addr=0xFFFFFF3E -> rsp_data=0x01003F3E (wrap, upper bits ignored).
REQ-032 SHALL pass: after reset, wr_valid and req_valid both high -> write granted first, fetch next cycle; a following tie grants write again only after that fetch.
REQ-033 SHALL pass: write 0xAA to address 0x05, then fetch 0x04 -> rsp_data=0x0706AA04.
REQ-034 SHALL pass: rsp_ready low for 3 cycles in RESP -> rsp_data stable, req_ready=0, wr_ready=0, and return to IDLE on the rsp_ready cycle.
REQ-035 SHALL pass: reset asserted during READ cnt=2 -> next cycle IDLE, rsp_valid=0, rsp_data=0, mem_we=0.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer sharing a byte-wide instruction memory port between a core
// fetch path (4-byte little-endian reads) and a loader write path.

module imem_fetch_byte_lane #(
  parameter int W    = 8,
  parameter int LANE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture,
  input  logic [1:0]   cnt,
  input  logic [W-1:0] rdata,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)                             q <= '0;
    else if (capture && cnt == 2'(LANE))   q <= rdata;
  end
endmodule

module imem_fetch_sequencer #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid,
  input  logic [4*W-1:0] req_addr,
  output logic           req_ready,
  output logic           rsp_valid,
  output logic [4*W-1:0] rsp_data,
  input  logic           rsp_ready,
  input  logic           wr_valid,
  input  logic [5:0]     wr_addr,
  input  logic [W-1:0]   wr_data,
  output logic           wr_ready,
  output logic [5:0]     mem_addr,
  output logic           mem_we,
  output logic [W-1:0]   mem_wdata,
  input  logic [W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t     state, state_nxt;
  logic [5:0] base;
  logic [1:0] cnt;
  logic       last_fetch;   // 1: the fetch side won the most recent grant
  logic       grant_wr, grant_rd;
  logic       capture;

  // Only the low six address bits reach the 64-entry memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[4*W-1:6];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      cnt        <= '0;
      last_fetch <= 1'b1;
    end else begin
      state <= state_nxt;
      if (grant_rd) begin
        base <= req_addr[5:0];
        cnt  <= '0;
      end else if (state == READ) begin
        cnt <= cnt + 2'd1;
      end
      if (grant_rd)      last_fetch <= 1'b1;
      else if (grant_wr) last_fetch <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        // On a tie the side that lost last time wins.
        if (wr_valid && req_valid) begin
          grant_wr = last_fetch;
          grant_rd = ~last_fetch;
        end else begin
          grant_wr = wr_valid;
          grant_rd = req_valid;
        end
        if (grant_wr) begin
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
        end
        if (grant_rd) state_nxt = READ;
      end
      READ: begin
        mem_addr = base + {4'b0, cnt};
        if (cnt == 2'd3) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = grant_rd;
  assign wr_ready  = grant_wr;
  assign rsp_valid = (state == RESP);
  assign capture   = (state == READ);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    imem_fetch_byte_lane #(.W(W), .LANE(i)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .capture (capture),
      .cnt     (cnt),
      .rdata   (mem_rdata),
      .q       (rsp_data[i*W +: W])
    );
  end
endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed scenarios plus randomized traffic
// checked against a byte-array memory model and a last-winner arbitration model.

module tb_imem_fetch_sequencer;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset, req_valid, rsp_ready, wr_valid;
  logic        req_ready, rsp_valid, wr_ready, mem_we;
  logic [31:0] req_addr, rsp_data;
  logic [5:0]  wr_addr, mem_addr;
  logic [7:0]  wr_data, mem_wdata, mem_rdata;

  logic [7:0]  mem     [64];
  logic [7:0]  ref_mem [64];
  bit          last_fetch_m;
  int          vectors = 0;
  int          errors  = 0;

  imem_fetch_sequencer #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  function automatic logic [31:0] ref_word(input logic [5:0] a);
    logic [5:0] p;
    ref_word = '0;
    for (int k = 0; k < 4; k++) begin
      p = a + 6'(k);
      ref_word[k*8 +: 8] = ref_mem[p];
    end
  endfunction

  task automatic test_reset();
    reset = 1; req_valid = 0; wr_valid = 0; rsp_ready = 0;
    req_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    reset = 0; #1;
    vectors++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    vectors++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    vectors++; if ({req_ready, wr_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_idle_outputs: got %b want 000", {req_ready, wr_ready, mem_we}); end
    last_fetch_m = 1;
  endtask

  task automatic test_fetch_basic();
    logic [31:0] addrs [2];
    logic [31:0] exps  [2];
    logic [5:0]  ea;
    addrs = '{32'h0000_0004, 32'hFFFF_FF3E};
    exps  = '{32'h0706_0504, 32'h0100_3F3E};
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); req_valid = 1; req_addr = addrs[n]; rsp_ready = 1; #1;
      vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL fetch_accept: got %b want 1", req_ready); end
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk); req_valid = 0; #1;
        if (k <= 4) begin
          ea = addrs[n][5:0] + 6'(k - 1);
          vectors++;
          if (mem_addr !== ea || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_read_addr: got addr %h we %b vld %b want addr %h we 0 vld 0", mem_addr, mem_we, rsp_valid, ea);
          end
        end else begin
          vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL fetch_latency: got rsp_valid %b want 1 at T+5", rsp_valid); end
          vectors++; if (rsp_data !== exps[n]) begin errors++; $display("FAIL fetch_data: got %h want %h", rsp_data, exps[n]); end
        end
      end
    end
    last_fetch_m = 1;
  endtask

  task automatic test_write_then_fetch();
    @(negedge clk); wr_valid = 1; wr_addr = 6'h05; wr_data = 8'hAA; #1;
    vectors++;
    if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'h05 || mem_wdata !== 8'hAA) begin
      errors++; $display("FAIL write_grant: got rdy %b we %b addr %h data %h want 1 1 05 aa", wr_ready, mem_we, mem_addr, mem_wdata);
    end
    ref_mem[5] = 8'hAA; last_fetch_m = 0;
    @(negedge clk); wr_valid = 0; req_valid = 1; req_addr = 32'h4; rsp_ready = 1; #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wtf_accept: got %b want 1", req_ready); end
    @(negedge clk); req_valid = 0;
    repeat (4) @(negedge clk);
    #1;
    vectors++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wtf_valid: got %b want 1", rsp_valid); end
    vectors++; if (rsp_data !== 32'h0706_AA04) begin errors++; $display("FAIL wtf_data: got %h want 0706aa04", rsp_data); end
    last_fetch_m = 1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1, e0, e1;
    a0 = $urandom; a1 = $urandom;
    e0 = ref_word(a0[5:0]); e1 = ref_word(a1[5:0]);
    @(negedge clk); req_valid = 1; req_addr = a0; rsp_ready = 1; #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept0: got %b want 1", req_ready); end
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); if (k == 1) req_addr = a1; #1;
      if (k < 6) begin
        vectors++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: got req_ready %b want 0 at T+%0d", req_ready, k); end
      end else begin
        vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept1: got %b want 1 at T+6", req_ready); end
      end
      if (k == 5) begin
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== e0) begin errors++; $display("FAIL b2b_rsp0: got vld %b data %h want 1 %h", rsp_valid, rsp_data, e0); end
      end
    end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); req_valid = 0;
    end
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== e1) begin errors++; $display("FAIL b2b_rsp1: got vld %b data %h want 1 %h", rsp_valid, rsp_data, e1); end
    last_fetch_m = 1;
  endtask

  task automatic test_arbitration();
    logic [31:0] e;
    @(negedge clk); reset = 1; req_valid = 0; wr_valid = 0;
    @(negedge clk); reset = 0;
    wr_valid = 1; wr_addr = 6'h30; wr_data = 8'h5C; req_valid = 1; req_addr = 32'h30; rsp_ready = 1; #1;
    vectors++; if (wr_ready !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL arb_first_tie: got wr %b req %b want 1 0", wr_ready, req_ready); end
    vectors++; if (mem_we !== 1'b1 || mem_addr !== 6'h30 || mem_wdata !== 8'h5C) begin errors++; $display("FAIL arb_write_port: got we %b addr %h data %h want 1 30 5c", mem_we, mem_addr, mem_wdata); end
    ref_mem[6'h30] = 8'h5C;
    e = ref_word(6'h30);
    @(negedge clk); wr_addr = 6'h31; wr_data = 8'h77; #1;
    vectors++; if (req_ready !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL arb_second_tie: got wr %b req %b want 0 1", wr_ready, req_ready); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      vectors++; if ({req_ready, wr_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL arb_wait: got %b want 000 at T+%0d", {req_ready, wr_ready, mem_we}, k); end
      if (k == 5) begin
        vectors++; if (rsp_valid !== 1'b1 || rsp_data !== e) begin errors++; $display("FAIL arb_rsp: got vld %b data %h want 1 %h", rsp_valid, rsp_data, e); end
      end
    end
    @(negedge clk); #1;
    vectors++; if (wr_ready !== 1'b1 || req_ready !== 1'b0 || mem_addr !== 6'h31) begin errors++; $display("FAIL arb_third_tie: got wr %b req %b addr %h want 1 0 31", wr_ready, req_ready, mem_addr); end
    ref_mem[6'h31] = 8'h77;
    @(negedge clk); #1;
    vectors++; if (req_ready !== 1'b1 || wr_ready !== 1'b0) begin errors++; $display("FAIL arb_fourth_tie: got wr %b req %b want 0 1", wr_ready, req_ready); end
    @(negedge clk); req_valid = 0; wr_valid = 0; reset = 1;
    @(negedge clk); reset = 0;
    last_fetch_m = 1;
  endtask

  task automatic test_backpressure();
    logic [31:0] a, e;
    logic [5:0]  wa;
    logic [7:0]  wd;
    a = $urandom; e = ref_word(a[5:0]);
    wa = 6'($urandom); wd = 8'($urandom);
    @(negedge clk); req_valid = 1; req_addr = a; wr_valid = 0; rsp_ready = 0; #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", req_ready); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin wr_valid = 1; wr_addr = wa; wr_data = wd; req_addr = $urandom; end
      rsp_ready = (k == 8); #1;
      vectors++; if (req_ready !== 1'b0 || wr_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready: got req %b wr %b want 0 0 at T+%0d", req_ready, wr_ready, k); end
      vectors++;
      if (k >= 5) begin
        if (rsp_valid !== 1'b1 || rsp_data !== e) begin errors++; $display("FAIL bp_data: got vld %b data %h want 1 %h at T+%0d", rsp_valid, rsp_data, e, k); end
      end else if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_early_valid: got %b want 0 at T+%0d", rsp_valid, k);
      end
    end
    @(negedge clk); rsp_ready = 0; #1;
    vectors++; if (wr_ready !== 1'b1 || req_ready !== 1'b0 || mem_addr !== wa || mem_wdata !== wd) begin
      errors++; $display("FAIL bp_return_idle: got wr %b req %b addr %h data %h want 1 0 %h %h", wr_ready, req_ready, mem_addr, mem_wdata, wa, wd);
    end
    ref_mem[wa] = wd; last_fetch_m = 0;
    @(negedge clk); req_valid = 0; wr_valid = 0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] a, a2, e2;
    logic [5:0]  ea;
    a = $urandom; a2 = $urandom;
    @(negedge clk); req_valid = 1; req_addr = a; wr_valid = 0; rsp_ready = 1; #1;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_accept: got %b want 1", req_ready); end
    @(negedge clk); req_valid = 0;
    @(negedge clk);
    @(negedge clk); reset = 1; #1;
    ea = a[5:0] + 6'd2;
    vectors++; if (mem_addr !== ea || mem_we !== 1'b0) begin errors++; $display("FAIL abort_cnt2: got addr %h we %b want %h 0", mem_addr, mem_we, ea); end
    @(negedge clk); reset = 0; req_valid = 1; req_addr = a2; #1;
    vectors++; if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL abort_clear: got vld %b data %h we %b want 0 0 0", rsp_valid, rsp_data, mem_we); end
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got req_ready %b want 1", req_ready); end
    last_fetch_m = 1;
    e2 = ref_word(a2[5:0]);
    repeat (5) begin @(negedge clk); req_valid = 0; end
    #1;
    vectors++; if (rsp_valid !== 1'b1 || rsp_data !== e2) begin errors++; $display("FAIL abort_refetch: got vld %b data %h want 1 %h", rsp_valid, rsp_data, e2); end
  endtask

  task automatic test_random();
    bit          wv, rv, exp_w, exp_r;
    logic [31:0] a, e;
    logic [5:0]  wa;
    logic [7:0]  wd;
    int          stall;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      wv = 1'($urandom); rv = 1'($urandom);
      a = $urandom; wa = 6'($urandom); wd = 8'($urandom);
      wr_valid = wv; req_valid = rv; req_addr = a; wr_addr = wa; wr_data = wd;
      rsp_ready = 1'($urandom); #1;
      exp_w = 0; exp_r = 0;
      if (wv && rv) begin
        if (last_fetch_m) exp_w = 1; else exp_r = 1;
      end else begin
        exp_w = wv; exp_r = rv;
      end
      vectors++;
      if ({wr_ready, req_ready, mem_we} !== {exp_w, exp_r, exp_w}) begin
        errors++; $display("FAIL rand_grant: got wr %b req %b we %b want %b %b %b", wr_ready, req_ready, mem_we, exp_w, exp_r, exp_w);
      end
      if (exp_w) begin
        vectors++; if (mem_addr !== wa || mem_wdata !== wd) begin errors++; $display("FAIL rand_write: got %h/%h want %h/%h", mem_addr, mem_wdata, wa, wd); end
        ref_mem[wa] = wd; last_fetch_m = 0;
      end
      if (exp_r) begin
        last_fetch_m = 1;
        e = ref_word(a[5:0]);
        stall = $urandom_range(0, 3);
        for (int k = 1; k <= 5 + stall; k++) begin
          @(negedge clk);
          wr_valid = 1'($urandom); req_valid = 1'($urandom);
          wr_addr = 6'($urandom); req_addr = $urandom;
          rsp_ready = (k == 5 + stall); #1;
          vectors++; if ({wr_ready, req_ready, mem_we} !== 3'b000) begin errors++; $display("FAIL rand_busy: got %b want 000 at T+%0d", {wr_ready, req_ready, mem_we}, k); end
          vectors++; if (rsp_valid !== (k >= 5)) begin errors++; $display("FAIL rand_valid: got %b want %b at T+%0d", rsp_valid, (k >= 5), k); end
          if (k >= 5) begin
            vectors++; if (rsp_data !== e) begin errors++; $display("FAIL rand_data: got %h want %h", rsp_data, e); end
          end
        end
      end
    end
    @(negedge clk); wr_valid = 0; req_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    test_reset();
    test_fetch_basic();
    test_write_then_fetch();
    test_back_to_back();
    test_arbitration();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
